cu_decode_sequencer: RTL and testbench
======================================

# cu_decode_sequencer

Sequences one instruction at a time through the Control Unit's decode path: accepts a fetched word, pulses the decode unit, and waits for its ready response. It then checks a register scoreboard for RAW/WAW hazards and hands the decoded instruction to execute. It sits between the fetch handshake and the execute issue port inside the CU, and owns `decode_start` and `ID_stall` for the decode stage.

## Interface
- `DECODE_TIMEOUT`, 8: cycles allowed in WAIT before abort; only used with the watchdog compiled in.
- `soc_clk  in  1`  sole clock, all state on rising edge
- `CU_reset_n  in  1`  asynchronous, active-low reset
- `fetch_valid  in  1`  fetch word available
- `fetch_instr  in  32`  fetched instruction
- `fetch_ready  out  1`  sequencer can accept; high only in IDLE
- `decode_start  out  1`  one-cycle pulse to decode unit
- `dec_instr  out  32`  held instruction presented to decode unit
- `IDU_ready  in  1`  decode complete; decode fields below valid this cycle
- `dec_rd, dec_rs1, dec_rs2  in  5 each`  decoded register indices
- `dec_uses_rs1, dec_uses_rs2, dec_writes_rd  in  1 each`  operand usage flags
- `invalid_instruction  in  1`  decode error, sampled with `IDU_ready`
- `issue_valid  out  1`  decoded instruction offered to execute
- `issue_ready  in  1`  execute accepts
- `issue_rd  out  5`  captured rd (0 if not writing)
- `wb_valid  in  1`, `wb_rd  in  5`  writeback retire, clears pending bit
- `flush  in  1`  discard current instruction
- `ID_stall  out  1`  high while held in HAZARD
- `seq_error  out  1`  one-cycle pulse on invalid instruction or timeout
- `pending_mask  out  32`  scoreboard contents; bit 0 always 0

## Operation
- States: IDLE, DECODE, WAIT, HAZARD, ISSUE.
- IDLE: `fetch_ready`=1. If `fetch_valid`, capture `fetch_instr` into `dec_instr` and go to DECODE.
- DECODE: `decode_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `IDU_ready`, capture rd/rs1/rs2/flags. If `invalid_instruction`, pulse `seq_error` and go to IDLE with no issue. Otherwise go to HAZARD.
- HAZARD: hazard = (uses_rs1 & pending[rs1]) | (uses_rs2 & pending[rs2]) | (writes_rd & pending[rd]).
  - Any index 0 never hazards.
  - Hazard → stay, `ID_stall`=1. Clear → go to ISSUE.
- ISSUE: `issue_valid`=1 and `issue_rd` held. When `issue_ready`=1, set pending[rd] (if writes_rd and rd≠0) and go to IDLE.
- Scoreboard: a 32-bit mask, set only at issue and cleared by `wb_valid` at `wb_rd`.
  - The WAW stall guarantees at most one writer per register in flight.
  - If a set and a clear hit the same bit in one cycle, the set wins.
  - A `wb_valid` with `wb_rd`=0, or for a bit that is not set, is ignored.
- `flush` (any state): next state is IDLE and captured fields are dropped. `pending_mask` is not altered, because older issued instructions still retire. `flush` has priority over all transitions, including acceptance in ISSUE.

## Timing
- Reset values:
  - State IDLE.
  - `fetch_ready`=1.
  - `decode_start`, `issue_valid`, `ID_stall`, `seq_error` = 0.
  - `dec_instr`, `issue_rd`, `pending_mask` = 0.
- Minimum latency: fetch accepted at cycle 0, `decode_start` at 1, `IDU_ready` earliest at 2, HAZARD at 3, `issue_valid` at 4. The next `fetch_ready` comes one cycle after issue acceptance.
- Hazard evaluation uses the registered mask. A writeback at cycle n releases HAZARD at n+1, and ISSUE follows at n+2.
- `issue_valid` and `issue_rd` remain stable until accepted or flushed.
- Reset asserted mid-operation returns to IDLE immediately, clears the mask and abandons any pending instruction.

## Configuration
- `CU_SEQ_WATCHDOG_EN` defined:
  - A counter runs in WAIT. On reaching `DECODE_TIMEOUT` cycles without `IDU_ready`, the sequencer pulses `seq_error`, drops the instruction and goes to IDLE.
  - The counter clears on every WAIT entry.
- `CU_SEQ_WATCHDOG_EN` undefined: no counter exists, WAIT waits indefinitely, and `DECODE_TIMEOUT` is unused.

## Structure
- Package `cu_seq_pkg`: state enum, `REG_X0` constant, and register-index width typedef.
- Sub-module `cu_scoreboard`: pending mask with set/clear ports, set-wins rule, and combinational hazard query.

## Test plan
- Basic flow: fetch `0x00500093` (addi x1,x0,5), with `IDU_ready` 1 cycle after `decode_start` and `issue_ready`=1 → `issue_valid` at cycle 4, `issue_rd`=1, pending_mask=`0x00000002`.
- RAW stall: issue a write to x1, then an instruction using rs1=x1 → `ID_stall` held high. A `wb_valid` with `wb_rd`=1 at cycle n → `ID_stall` low at n+1, `issue_valid` at n+2.
- WAW plus x0: a second write to x1 stalls. A write to x0 never sets a bit and never stalls.
- Invalid instruction: `invalid_instruction`=1 with `IDU_ready` → `seq_error` pulse of 1 cycle, no `issue_valid`, `fetch_ready`=1 the next cycle.
- Flush in ISSUE with `issue_ready`=1 on the same cycle → no scoreboard set, IDLE next cycle.
- Watchdog (macro on, `DECODE_TIMEOUT`=8): `IDU_ready` never arrives → `seq_error` 8 cycles after WAIT entry, then IDLE. With the macro off, the sequencer stays in WAIT for 50 cycles.

Source files
------------

// File: rtl/cu_seq_pkg.sv
// cu_seq_pkg: shared state encoding and register-index types for the decode sequencer.
package cu_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_HAZARD, S_ISSUE} seq_state_e;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_X0 = 5'd0;
endpackage

// File: rtl/cu_scoreboard.sv
// cu_scoreboard: pending-writer mask with set/clear ports (set wins) and a combinational hazard query.
module cu_scoreboard
  import cu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  reg_idx_t    set_idx,
  input  logic        clr_en,
  input  reg_idx_t    clr_idx,
  input  reg_idx_t    q_rs1,
  input  reg_idx_t    q_rs2,
  input  reg_idx_t    q_rd,
  output logic        hazard,
  output logic [31:0] mask
);
  logic [31:0] mask_q, mask_d;
  always_comb begin
    mask_d = mask_q;
    mask_d = clr_en ? mask_d & ~(32'd1 << clr_idx) : mask_d;
    mask_d = set_en ? mask_d | (32'd1 << set_idx) : mask_d;
    mask_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask_q <= '0;
    else mask_q <= mask_d;
  assign hazard = (q_rs1 != REG_X0 && mask_q[q_rs1]) |
                  (q_rs2 != REG_X0 && mask_q[q_rs2]) |
                  (q_rd  != REG_X0 && mask_q[q_rd]);
  assign mask = mask_q;
endmodule

// File: rtl/cu_decode_sequencer.sv
// cu_decode_sequencer: one-at-a-time fetch -> decode -> hazard -> issue sequencer for the CU.
// Optional decode watchdog compiled in with CU_SEQ_WATCHDOG_EN.
module cu_decode_sequencer
  import cu_seq_pkg::*;
#(
  parameter int unsigned DECODE_TIMEOUT = 8
) (
  input  logic        soc_clk,
  input  logic        CU_reset_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  output logic        fetch_ready,
  output logic        decode_start,
  output logic [31:0] dec_instr,
  input  logic        IDU_ready,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_uses_rs1,
  input  logic        dec_uses_rs2,
  input  logic        dec_writes_rd,
  input  logic        invalid_instruction,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        ID_stall,
  output logic        seq_error,
  output logic [31:0] pending_mask
);
  seq_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  reg_idx_t    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        err_q, err_d;
  logic        hazard, timeout;
`ifdef CU_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(DECODE_TIMEOUT + 1);
  logic [CW-1:0] wd_q, wd_d;
  // Counter is zero in every non-WAIT state, so it restarts on each WAIT entry.
  always_comb wd_d = (state_q == S_WAIT) ? wd_q + CW'(1) : '0;
  always_ff @(posedge soc_clk or negedge CU_reset_n)
    if (!CU_reset_n) wd_q <= '0;
    else wd_q <= wd_d;
  assign timeout = state_q == S_WAIT && !IDU_ready && wd_q == CW'(DECODE_TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = fetch_valid ? S_DECODE : S_IDLE;
        instr_d = fetch_valid ? fetch_instr : instr_q;
      end
      S_DECODE: state_d = S_WAIT;
      S_WAIT: begin
        err_d = (IDU_ready & invalid_instruction) | timeout;
        // Unused operands are stored as x0 so the hazard query needs no usage flags.
        if (IDU_ready && !invalid_instruction) begin
          rd_d    = dec_writes_rd ? dec_rd : REG_X0;
          rs1_d   = dec_uses_rs1 ? dec_rs1 : REG_X0;
          rs2_d   = dec_uses_rs2 ? dec_rs2 : REG_X0;
          state_d = S_HAZARD;
        end else if (err_d) state_d = S_IDLE;
      end
      S_HAZARD: state_d = hazard ? S_HAZARD : S_ISSUE;
      S_ISSUE:  state_d = issue_ready ? S_IDLE : S_ISSUE;
      default:  state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      rd_d    = REG_X0;
      rs1_d   = REG_X0;
      rs2_d   = REG_X0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge soc_clk or negedge CU_reset_n)
    if (!CU_reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      rd_q    <= REG_X0;
      rs1_q   <= REG_X0;
      rs2_q   <= REG_X0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      err_q   <= err_d;
    end
  cu_scoreboard u_sb (
    .clk    (soc_clk),
    .rst_n  (CU_reset_n),
    .set_en (state_q == S_ISSUE && issue_ready && !flush && rd_q != REG_X0),
    .set_idx(rd_q),
    .clr_en (wb_valid && wb_rd != REG_X0),
    .clr_idx(wb_rd),
    .q_rs1  (rs1_q),
    .q_rs2  (rs2_q),
    .q_rd   (rd_q),
    .hazard (hazard),
    .mask   (pending_mask)
  );
  assign fetch_ready  = state_q == S_IDLE;
  assign decode_start = state_q == S_DECODE;
  assign issue_valid  = state_q == S_ISSUE;
  assign ID_stall     = state_q == S_HAZARD && hazard;
  assign seq_error    = err_q;
  assign dec_instr    = instr_q;
  assign issue_rd     = rd_q;
endmodule

// File: tb/tb_cu_decode_sequencer.sv
// tb_cu_decode_sequencer: directed stimulus with a queue-based issue/error scoreboard.
module tb_cu_decode_sequencer;
  logic        clk = 0, rst_n = 0;
  logic        fetch_valid = 0, IDU_ready = 0, invalid_instruction = 0;
  logic [31:0] fetch_instr = 0;
  logic [4:0]  dec_rd = 0, dec_rs1 = 0, dec_rs2 = 0, wb_rd = 0;
  logic        dec_uses_rs1 = 0, dec_uses_rs2 = 0, dec_writes_rd = 0;
  logic        issue_ready = 0, wb_valid = 0, flush = 0;
  logic        fetch_ready, decode_start, issue_valid, ID_stall, seq_error;
  logic [31:0] dec_instr, pending_mask;
  logic [4:0]  issue_rd;
  int errors = 0, checks = 0, err_exp = 0;
  logic [4:0] exp_q[$];
  always #5 clk = ~clk;
  cu_decode_sequencer #(.DECODE_TIMEOUT(8)) dut (
    .soc_clk(clk), .CU_reset_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
    .decode_start(decode_start), .dec_instr(dec_instr),
    .IDU_ready(IDU_ready), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_writes_rd(dec_writes_rd),
    .invalid_instruction(invalid_instruction),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .ID_stall(ID_stall), .seq_error(seq_error), .pending_mask(pending_mask)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // Runs IDLE -> DECODE -> WAIT with IDU_ready on the first WAIT cycle; returns one cycle later.
  task automatic fetch_decode(input logic [31:0] ins, input logic [4:0] rd, rs1, rs2,
                              input logic u1, u2, wr, inv);
    chk("fetch_ready_idle", fetch_ready, 1);
    fetch_valid = 1; fetch_instr = ins;
    step();
    fetch_valid = 0; fetch_instr = 32'hdeadbeef;
    chk("decode_start", decode_start, 1);
    chk("dec_instr", dec_instr, ins);
    step();
    chk("decode_start_pulse", decode_start, 0);
    IDU_ready = 1; invalid_instruction = inv;
    dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_uses_rs1 = u1; dec_uses_rs2 = u2; dec_writes_rd = wr;
    step();
    IDU_ready = 0; invalid_instruction = 0;
    dec_rd = 5'h1f; dec_rs1 = 5'h1f; dec_rs2 = 5'h1f;
    dec_uses_rs1 = 1; dec_uses_rs2 = 1; dec_writes_rd = 1;
  endtask
  always @(negedge clk) if (rst_n) begin
    if (issue_valid && issue_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_unexpected: got rd=%0d expected no issue", issue_rd);
      end else chk("issue_rd_sb", issue_rd, exp_q.pop_front());
    end
    if (seq_error) begin
      if (err_exp == 0) begin
        checks++; errors++;
        $display("FAIL seq_error_unexpected: got 1 expected 0");
      end else begin
        checks++;
        err_exp--;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    step(2);
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_decode_start", decode_start, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_id_stall", ID_stall, 0);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_issue_rd", issue_rd, 0);
    chk("rst_pending", pending_mask, 0);
    rst_n = 1;
    step();
    // basic: addi x1,x0,5
    issue_ready = 1; exp_q.push_back(5'd1);
    fetch_decode(32'h00500093, 5'd1, 5'd0, 5'd0, 1, 0, 1, 0);
    chk("basic_no_stall", ID_stall, 0);
    chk("basic_not_yet", issue_valid, 0);
    step();
    chk("basic_issue_c4", issue_valid, 1);
    chk("basic_issue_rd", issue_rd, 1);
    step();
    chk("basic_pending", pending_mask, 32'h2);
    chk("basic_ready_again", fetch_ready, 1);
    // RAW: add x5,x1,x0 waits for x1 writeback
    exp_q.push_back(5'd5);
    fetch_decode(32'h000082b3, 5'd5, 5'd1, 5'd0, 1, 1, 1, 0);
    chk("raw_stall", ID_stall, 1);
    step(3);
    chk("raw_stall_held", ID_stall, 1);
    chk("raw_no_issue", issue_valid, 0);
    wb_valid = 1; wb_rd = 5'd1;
    step();
    wb_valid = 0;
    chk("raw_release_n1", ID_stall, 0);
    chk("raw_not_issued_n1", issue_valid, 0);
    chk("raw_mask_cleared", pending_mask, 0);
    step();
    chk("raw_issue_n2", issue_valid, 1);
    chk("raw_issue_rd", issue_rd, 5);
    step();
    chk("raw_pending", pending_mask, 32'h20);
    // WAW on x5, then set and clear of x5 in the same cycle
    exp_q.push_back(5'd5);
    fetch_decode(32'h00100293, 5'd5, 5'd0, 5'd0, 0, 0, 1, 0);
    chk("waw_stall", ID_stall, 1);
    step(2);
    chk("waw_stall_held", ID_stall, 1);
    wb_valid = 1; wb_rd = 5'd5;
    step();
    wb_valid = 0;
    chk("waw_release", ID_stall, 0);
    chk("waw_mask_cleared", pending_mask, 0);
    step();
    chk("waw_issue", issue_valid, 1);
    wb_valid = 1; wb_rd = 5'd5;
    step();
    wb_valid = 0;
    chk("set_wins", pending_mask, 32'h20);
    // write to x0 plus ignored writebacks
    exp_q.push_back(5'd0);
    fetch_decode(32'h00000013, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
    chk("x0_no_stall", ID_stall, 0);
    wb_valid = 1; wb_rd = 5'd0;
    step();
    wb_rd = 5'd2;
    chk("x0_issue", issue_valid, 1);
    chk("x0_issue_rd", issue_rd, 0);
    step();
    wb_valid = 0;
    chk("x0_pending", pending_mask, 32'h20);
    // invalid instruction
    err_exp++;
    fetch_decode(32'hffffffff, 5'd4, 5'd0, 5'd0, 0, 0, 1, 1);
    chk("inv_seq_error", seq_error, 1);
    chk("inv_fetch_ready", fetch_ready, 1);
    chk("inv_no_issue", issue_valid, 0);
    step();
    chk("inv_pulse_one", seq_error, 0);
    chk("inv_pending", pending_mask, 32'h20);
    // flush in ISSUE with issue_ready high
    fetch_decode(32'h00100393, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0);
    step();
    chk("flush_in_issue", issue_valid, 1);
    flush = 1;
    step();
    flush = 0;
    chk("flush_idle", fetch_ready, 1);
    chk("flush_no_set", pending_mask, 32'h20);
    // issue held stable while execute is busy
    issue_ready = 0;
    fetch_decode(32'h00100493, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0);
    step();
    chk("hold_issue", issue_valid, 1);
    step(3);
    chk("hold_issue_valid", issue_valid, 1);
    chk("hold_issue_rd", issue_rd, 9);
    chk("hold_not_ready", fetch_ready, 0);
    exp_q.push_back(5'd9);
    issue_ready = 1;
    step();
    chk("hold_pending", pending_mask, 32'h220);
    chk("hold_idle", fetch_ready, 1);
    // decode unit never answers
    chk("wd_fetch_ready", fetch_ready, 1);
    fetch_valid = 1; fetch_instr = 32'h00000013;
    step();
    fetch_valid = 0;
    step();
`ifdef CU_SEQ_WATCHDOG_EN
    err_exp++;
    step(7);
    chk("wd_still_wait", fetch_ready, 0);
    chk("wd_no_error_yet", seq_error, 0);
    step();
    chk("wd_seq_error", seq_error, 1);
    chk("wd_idle", fetch_ready, 1);
    step();
    chk("wd_pulse_one", seq_error, 0);
`else
    step(50);
    chk("nowd_still_wait", fetch_ready, 0);
    chk("nowd_no_issue", issue_valid, 0);
    chk("nowd_no_error", seq_error, 0);
    flush = 1;
    step();
    flush = 0;
    chk("nowd_flush_idle", fetch_ready, 1);
`endif
    // reset mid-operation
    issue_ready = 0;
    fetch_decode(32'h00100193, 5'd3, 5'd0, 5'd0, 0, 0, 1, 0);
    step();
    chk("mid_in_issue", issue_valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_idle", fetch_ready, 1);
    chk("mid_rst_no_issue", issue_valid, 0);
    chk("mid_rst_pending", pending_mask, 0);
    chk("mid_rst_issue_rd", issue_rd, 0);
    step();
    rst_n = 1;
    step(2);
    chk("mid_rst_stays_idle", fetch_ready, 1);
    chk("sb_issue_drained", exp_q.size(), 0);
    chk("sb_error_drained", err_exp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
